// File: rtl/lcb_poll_ctrl.sv
// LCB poller: sends one request byte per poll, buffers the fixed-length reply and
// re-presents it to the frame decoder as level-held rawData/rxValid strobes.
//
// state   | meaning
// P_IDLE  | waiting for start
// P_SEND  | request byte offered to UART tx until tx_ready
// P_RECV  | collecting reply bytes, per-byte timeout running
// P_PAD   | reply timed out, filling with 8'h00 up to REPLY_BYTES
// P_DONE  | poll_done pulse, advance LCB index
// O_IDLE  | waiting for a buffered byte and decoder not busy
// O_HOLD  | rxValid high for VALID_HOLD cycles
// O_GAP   | rxValid low for at least GAP_CYC cycles and while decoder busy
module lcb_poll_ctrl #(
    parameter int NUM_LCB     = 24,
    parameter int REPLY_BYTES = 15,
    parameter int TIMEOUT_CYC = 4000,
    parameter int VALID_HOLD  = 8,
    parameter int GAP_CYC     = 2,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       tx_ready,
    output logic [7:0] tx_data,
    output logic       tx_load,
    input  logic [7:0] rx_data,
    input  logic       rx_strobe,
    output logic [7:0] rawData,
    output logic       rxValid,
    input  logic       lcb_busy,
    output logic [4:0] LCBrqNumber,
    output logic       poll_done,
    output logic       timeout_err,
    output logic       overrun_err
);

    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = $clog2(REPLY_BYTES + 1);
    localparam int TMR_W  = $clog2(TIMEOUT_CYC + 1);
    localparam int OMAX   = (VALID_HOLD > GAP_CYC) ? VALID_HOLD : GAP_CYC;
    localparam int OCNT_W = $clog2(OMAX + 1);

    localparam logic [AW:0]       PTR_ONE   = (AW + 1)'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  RB_LAST   = CNT_W'(REPLY_BYTES - 1);
    localparam logic [TMR_W-1:0]  TMR_ONE   = TMR_W'(1);
    localparam logic [TMR_W-1:0]  TMR_LOAD  = TMR_W'(TIMEOUT_CYC);
    localparam logic [OCNT_W-1:0] OCNT_ONE  = OCNT_W'(1);
    localparam logic [OCNT_W-1:0] HOLD_LOAD = OCNT_W'(VALID_HOLD - 1);
    localparam logic [OCNT_W-1:0] GAP_LOAD  = OCNT_W'(GAP_CYC - 1);
    localparam logic [4:0]        LCB_LAST  = 5'(NUM_LCB - 1);

    typedef enum logic [2:0] {P_IDLE, P_SEND, P_RECV, P_PAD, P_DONE} p_state_t;
    typedef enum logic [1:0] {O_IDLE, O_HOLD, O_GAP} o_state_t;

    p_state_t p_state, p_next;
    o_state_t o_state, o_next;

    logic [7:0]        fifo_mem [FIFO_DEPTH];
    logic [AW:0]       wr_ptr, rd_ptr;
    logic              fifo_full, fifo_empty;
    logic              push_req, push_ok, push_drop, pop;
    logic [7:0]        push_data;
    logic              strobe_drop;
    logic [CNT_W-1:0]  rx_cnt;
    logic [TMR_W-1:0]  tmr;
    logic [OCNT_W-1:0] ocnt;

    // ---------------- reply FIFO ----------------
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign push_ok    = push_req && (!fifo_full || pop);
    assign push_drop  = push_req && !push_ok;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)     rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) fifo_mem[wr_ptr[AW-1:0]] <= push_data;
    end

    // ---------------- poll FSM ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) p_state <= P_IDLE;
        else        p_state <= p_next;
    end

    always_comb begin
        p_next = p_state;
        case (p_state)
            P_IDLE: if (start) p_next = P_SEND;
            P_SEND: if (tx_ready) p_next = P_RECV;
            P_RECV: begin
                if (rx_strobe && (rx_cnt == RB_LAST)) p_next = P_DONE;
                else if (!rx_strobe && (tmr == '0))   p_next = P_PAD;
            end
            P_PAD:  if (push_req && (rx_cnt == RB_LAST)) p_next = P_DONE;
            P_DONE: p_next = P_IDLE;
            default: p_next = P_IDLE;
        endcase
    end

    always_comb begin
        tx_data   = 8'h00;
        tx_load   = 1'b0;
        poll_done = 1'b0;
        case (p_state)
            P_SEND: begin
                tx_data = {3'b101, LCBrqNumber};
                tx_load = tx_ready;
            end
            P_DONE: poll_done = 1'b1;
            default: ;
        endcase
    end

    // Pad bytes wait for FIFO room instead of being dropped, so framing needs no overrun.
    always_comb begin
        push_req    = 1'b0;
        push_data   = rx_data;
        strobe_drop = 1'b0;
        case (p_state)
            P_RECV: push_req = rx_strobe;
            P_PAD: begin
                push_req    = !fifo_full || pop;
                push_data   = 8'h00;
                strobe_drop = rx_strobe;
            end
            default: strobe_drop = rx_strobe;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_cnt      <= '0;
            tmr         <= '0;
            LCBrqNumber <= '0;
            timeout_err <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            case (p_state)
                P_SEND: begin
                    if (tx_ready) begin
                        rx_cnt <= '0;
                        tmr    <= TMR_LOAD;
                    end
                end
                P_RECV: begin
                    if (rx_strobe) begin
                        rx_cnt <= rx_cnt + CNT_ONE;
                        tmr    <= TMR_LOAD;
                    end else if (tmr != '0) begin
                        tmr <= tmr - TMR_ONE;
                    end
                end
                P_PAD:  if (push_req) rx_cnt <= rx_cnt + CNT_ONE;
                P_DONE: LCBrqNumber <= (LCBrqNumber == LCB_LAST) ? 5'd0 : LCBrqNumber + 5'd1;
                default: ;
            endcase
            if (p_state == P_IDLE && start) begin
                timeout_err <= 1'b0;
                overrun_err <= 1'b0;
            end
            if (p_state == P_RECV && p_next == P_PAD) timeout_err <= 1'b1;
            if (strobe_drop || push_drop)             overrun_err <= 1'b1;
        end
    end

    // ---------------- output pacing FSM ----------------
    assign pop = (o_state == O_IDLE) && !fifo_empty && !lcb_busy;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) o_state <= O_IDLE;
        else        o_state <= o_next;
    end

    always_comb begin
        o_next = o_state;
        case (o_state)
            O_IDLE: if (pop) o_next = O_HOLD;
            O_HOLD: if (ocnt == '0) o_next = O_GAP;
            O_GAP:  if ((ocnt == '0) && !lcb_busy) o_next = O_IDLE;
            default: o_next = O_IDLE;
        endcase
    end

    always_comb begin
        rxValid = (o_state == O_HOLD);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ocnt    <= '0;
            rawData <= 8'h00;
        end else begin
            case (o_state)
                O_IDLE: begin
                    if (pop) begin
                        ocnt    <= HOLD_LOAD;
                        rawData <= fifo_mem[rd_ptr[AW-1:0]];
                    end
                end
                O_HOLD: ocnt <= (ocnt == '0) ? GAP_LOAD : ocnt - OCNT_ONE;
                O_GAP:  if (ocnt != '0) ocnt <= ocnt - OCNT_ONE;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lcb_poll_ctrl.sv
// Randomized bench for lcb_poll_ctrl: byte-level scoreboard of expected decoder
// traffic plus per-poll checks of request byte, framing, LCB index and error flags.
module tb_lcb_poll_ctrl;

    localparam int NUM_LCB     = 24;
    localparam int REPLY_BYTES = 15;
    localparam int TIMEOUT_CYC = 4000;
    localparam int VALID_HOLD  = 8;
    localparam int GAP_CYC     = 2;

    logic       clk = 1'b0;
    logic       reset, start, tx_ready, rx_strobe, lcb_busy;
    logic [7:0] tx_data, rx_data, rawData;
    logic       tx_load, rxValid, poll_done, timeout_err, overrun_err;
    logic [4:0] LCBrqNumber;

    int         n_chk = 0;
    int         n_fail = 0;
    logic [7:0] exp_q[$];
    int         n_txload = 0, n_done = 0, n_deliv = 0;
    logic [7:0] last_tx = 8'h00;
    int         model_lcb = 0;
    bit         busy_rand = 0, bp_arm = 0;
    int         bp_ref = 0, bp_cnt = 0;

    logic       mon_v_prev = 1'b0, mon_busy_prev = 1'b0;
    int         mon_hi = 0, mon_lo = 100;
    logic [7:0] mon_held = 8'h00;

    lcb_poll_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .tx_ready(tx_ready),
        .tx_data(tx_data), .tx_load(tx_load), .rx_data(rx_data), .rx_strobe(rx_strobe),
        .rawData(rawData), .rxValid(rxValid), .lcb_busy(lcb_busy),
        .LCBrqNumber(LCBrqNumber), .poll_done(poll_done),
        .timeout_err(timeout_err), .overrun_err(overrun_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Decoder-side monitor: ordering, hold length, stability, gap and busy discipline.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                mon_v_prev    = 1'b0;
                mon_busy_prev = 1'b0;
                mon_hi        = 0;
                mon_lo        = 100;
            end else begin
                if (rxValid && !mon_v_prev) begin
                    chk("busy_at_pop", mon_busy_prev, 0);
                    chk("gap_len_ok", mon_lo >= GAP_CYC, 1);
                    chk("byte_avail", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) chk("rawData", rawData, exp_q.pop_front());
                    mon_held = rawData;
                    mon_hi   = 1;
                    n_deliv++;
                end else if (rxValid) begin
                    mon_hi++;
                    if (rawData !== mon_held) chk("rawData_stable", rawData, mon_held);
                end else if (mon_v_prev) begin
                    chk("valid_len", mon_hi, VALID_HOLD);
                    mon_lo = 1;
                end else begin
                    mon_lo++;
                end
                if (tx_load) begin
                    n_txload++;
                    last_tx = tx_data;
                end
                if (poll_done) n_done++;
                mon_v_prev    = rxValid;
                mon_busy_prev = lcb_busy;
            end
        end
    end

    initial begin
        lcb_busy = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (bp_arm && n_deliv > bp_ref) begin
                bp_cnt = 50;
                bp_arm = 0;
            end
            if (bp_cnt > 0) begin
                lcb_busy = 1'b1;
                bp_cnt--;
            end else begin
                lcb_busy = busy_rand ? ($urandom_range(0, 3) == 0) : 1'b0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no finish, expected finish before 1ms");
        $fatal(1);
    end

    task automatic wait_drain();
        int guard = 0;
        while ((exp_q.size() != 0 || rxValid) && guard < 3000) begin
            tick();
            guard++;
        end
        chk("drain", exp_q.size(), 0);
        repeat (4) tick();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_tx_data"}, tx_data, 0);
        chk({tag, "_tx_load"}, tx_load, 0);
        chk({tag, "_rawData"}, rawData, 0);
        chk({tag, "_rxValid"}, rxValid, 0);
        chk({tag, "_lcb"}, LCBrqNumber, 0);
        chk({tag, "_poll_done"}, poll_done, 0);
        chk({tag, "_timeout"}, timeout_err, 0);
        chk({tag, "_overrun"}, overrun_err, 0);
    endtask

    // One full poll: nb reply bytes from the "LCB", remainder expected as padding.
    task automatic run_poll(input int nb, input bit seq);
        int tl0, d0, lcb, guard;
        logic [7:0] b;
        wait_drain();
        tl0 = n_txload;
        d0  = n_done;
        lcb = model_lcb;
        tx_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_clears_timeout", timeout_err, 0);
        chk("start_clears_overrun", overrun_err, 0);
        repeat ($urandom_range(0, 3)) tick();
        tx_ready = 1'b1;
        guard = 0;
        while (n_txload == tl0 && guard < 20) begin
            tick();
            guard++;
        end
        chk("tx_load_seen", n_txload != tl0, 1);
        chk("tx_data", last_tx, {3'b101, 5'(lcb)});
        for (int i = 0; i < nb; i++) begin
            repeat ($urandom_range(0, 4)) tick();
            b = seq ? 8'(8'h10 + i) : 8'($urandom);
            rx_data   = b;
            rx_strobe = 1'b1;
            exp_q.push_back(b);
            tick();
            rx_strobe = 1'b0;
        end
        tx_ready = 1'b0;
        if (nb < REPLY_BYTES) begin
            for (int i = nb; i < REPLY_BYTES; i++) exp_q.push_back(8'h00);
            repeat (TIMEOUT_CYC - 10) tick();
            chk("no_early_timeout", timeout_err, 0);
            chk("no_early_done", n_done - d0, 0);
        end
        guard = 0;
        while (n_done == d0 && guard < TIMEOUT_CYC + 100) begin
            tick();
            guard++;
        end
        chk("poll_done_seen", n_done != d0, 1);
        repeat (3) tick();
        chk("poll_done_once", n_done - d0, 1);
        chk("tx_load_once", n_txload - tl0, 1);
        chk("lcb_next", LCBrqNumber, (lcb + 1) % NUM_LCB);
        chk("timeout_err", timeout_err, nb < REPLY_BYTES);
        chk("overrun_err", overrun_err, 0);
        model_lcb = (lcb + 1) % NUM_LCB;
    endtask

    initial begin
        int guard;
        int tl0;
        logic [7:0] b;
        reset = 1'b0; start = 1'b0; tx_ready = 1'b0; rx_strobe = 1'b0; rx_data = 8'h00;
        repeat (3) tick();
        check_all_zero("in_reset");
        reset = 1'b1;
        tick();
        tick();
        check_all_zero("after_reset");

        busy_rand = 1;
        for (int p = 0; p < 3; p++) run_poll(REPLY_BYTES, 0);

        busy_rand = 0;
        run_poll(REPLY_BYTES, 1);
        chk("nominal_req_byte", last_tx, 8'hA3);
        chk("nominal_lcb", LCBrqNumber, 4);

        run_poll(9, 0);

        bp_ref = n_deliv;
        bp_arm = 1;
        run_poll(REPLY_BYTES, 0);
        chk("backpressure_applied", bp_arm, 0);

        busy_rand = 1;
        while (model_lcb != NUM_LCB - 1) run_poll(REPLY_BYTES, 0);
        run_poll(REPLY_BYTES, 0);
        chk("wrap_to_zero", LCBrqNumber, 0);

        rx_data   = 8'h5A;
        rx_strobe = 1'b1;
        tick();
        rx_strobe = 1'b0;
        tick();
        chk("overrun_set", overrun_err, 1);
        run_poll(REPLY_BYTES, 0);

        wait_drain();
        tl0 = n_txload;
        tx_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        guard = 0;
        while (n_txload == tl0 && guard < 20) begin
            tick();
            guard++;
        end
        chk("mid_tx_load_seen", n_txload != tl0, 1);
        for (int i = 0; i < 5; i++) begin
            b = 8'($urandom);
            rx_data   = b;
            rx_strobe = 1'b1;
            exp_q.push_back(b);
            tick();
            rx_strobe = 1'b0;
        end
        tx_ready = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        check_all_zero("mid_reset");
        exp_q.delete();
        model_lcb = 0;
        tick();
        reset = 1'b1;
        tick();
        chk("post_reset_lcb", LCBrqNumber, 0);
        run_poll(REPLY_BYTES, 0);
        chk("post_reset_req_byte", last_tx, 8'hA0);
        wait_drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
